// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the zilla_32 memory-access stage.
// Provides load/store funct3 encodings, the MEM FSM state type and small
// helpers for access-size decoding (misalignment, byte enables, store lanes).
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_state_t;

  // Size is funct3[1:0]; the reserved code 11 is handled as a word access.
  function automatic logic is_misaligned(logic [2:0] f3, logic [1:0] lo);
    case (f3[1:0])
      F3_LB[1:0]: return 1'b0;
      F3_LH[1:0]: return lo[0];
      default:    return |lo;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(logic [2:0] f3, logic [1:0] lo);
    case (f3[1:0])
      F3_SB[1:0]: return 4'b0001 << lo;
      F3_SH[1:0]: return lo[1] ? 4'b1100 : 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

  // Store data is replicated so every lane carries the value; be selects.
  function automatic logic [31:0] lane_wdata(logic [2:0] f3, logic [31:0] d);
    case (f3[1:0])
      F3_SB[1:0]: return {4{d[7:0]}};
      F3_SH[1:0]: return {2{d[15:0]}};
      F3_SW[1:0]: return d;
      default:    return d;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the addressed byte/halfword out of the read word
// and sign- or zero-extends it according to funct3.
// Ports:
//   i_rdata    32  word returned by data memory
//   i_addr_lo   2  byte offset of the access
//   i_funct3    3  load size/sign
//   o_data_c   32  extended load value (combinational)
module load_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select, then extension
  always_comb begin
    w_byte   = 8'h00;
    w_half   = 16'h0000;
    o_data_c = i_rdata;
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_funct3)
      F3_LB:   o_data_c = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_data_c = {24'h000000, w_byte};
      F3_LH:   o_data_c = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_data_c = {16'h0000, w_half};
      F3_LW:   o_data_c = i_rdata;
      default: o_data_c = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// zilla_32 MEM stage: passes ALU results to write-back and performs loads and
// stores on the data memory over a req/ack handshake. Stalls upstream while a
// request is outstanding. All write-back outputs are registered (MEM/WB).
// Optional feature macro: MEM_ACK_TIMEOUT_EN -- abandon a request after
// ACK_TIMEOUT cycles without ack and complete with wb_bus_err.
// Ports:
//   risc_clk, risc_rst_n (sync, active-low)
//   ex_*      instruction from execute (valid, address/result, store data, rd,
//             funct3, load/store/writes-GPR flags)
//   mem_stall upstream hold
//   dmem_*    data memory request/response
//   wb_*      registered result to write-back (valid, rd, data, flags)
module mem_access_stage
  import riscv_mem_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic            risc_clk,
  input  logic            risc_rst_n,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_alu_out,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [4:0]      ex_rd,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_load_en,
  input  logic            ex_store_en,
  input  logic            ex_wr_data_en,
  output logic            mem_stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic            wb_wr_data_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_misalign,
  output logic            wb_bus_err
);

  if (XLEN != 32 || ACK_TIMEOUT == 0) begin : g_param_check
    $error("mem_access_stage: XLEN must be 32 and ACK_TIMEOUT nonzero");
  end

  mem_state_t      r_state, w_state_nxt;
  logic            r_dmem_we, w_dmem_we_nxt;
  logic [XLEN-1:0] r_dmem_addr, w_dmem_addr_nxt;
  logic [XLEN-1:0] r_dmem_wdata, w_dmem_wdata_nxt;
  logic [3:0]      r_dmem_be, w_dmem_be_nxt;
  logic [1:0]      r_addr_lo, w_addr_lo_nxt;
  logic [2:0]      r_funct3, w_funct3_nxt;
  logic [4:0]      r_rd, w_rd_nxt;
  logic            r_wr_en, w_wr_en_nxt;
  logic            r_is_load, w_is_load_nxt;
  logic            r_wb_valid, w_wb_valid_nxt;
  logic            r_wb_wr_data_en, w_wb_wr_data_en_nxt;
  logic [4:0]      r_wb_rd, w_wb_rd_nxt;
  logic [XLEN-1:0] r_wb_data, w_wb_data_nxt;
  logic            r_wb_misalign, w_wb_misalign_nxt;
  logic            r_wb_bus_err, w_wb_bus_err_nxt;

  logic            w_is_mem;
  logic            w_misalign;
  logic            w_enter_req;
  logic            w_timeout;
  logic [XLEN-1:0] w_load_data;

  assign w_is_mem   = ex_load_en | ex_store_en;
  assign w_misalign = is_misaligned(ex_funct3, ex_alu_out[1:0]);

  load_align u_load_align (
    .i_rdata   (dmem_rdata),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_funct3),
    .o_data_c  (w_load_data)
  );

`ifdef MEM_ACK_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic [CNT_W-1:0] r_to_cnt;

  // Expiry fires in the ACK_TIMEOUT-th REQ cycle; an ack that cycle wins
  assign w_timeout = (r_state == REQ) && !dmem_ack &&
                     (r_to_cnt == CNT_W'(ACK_TIMEOUT - 1));

  // Cycles spent in REQ without ack
  always_ff @(posedge risc_clk) begin
    if (!risc_rst_n) begin
      r_to_cnt <= '0;
    end else if (w_enter_req) begin
      r_to_cnt <= '0;
    end else if (r_state == REQ && !dmem_ack) begin
      r_to_cnt <= r_to_cnt + CNT_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Next state and next values of every registered output
  always_comb begin
    w_state_nxt         = r_state;
    w_dmem_we_nxt       = r_dmem_we;
    w_dmem_addr_nxt     = r_dmem_addr;
    w_dmem_wdata_nxt    = r_dmem_wdata;
    w_dmem_be_nxt       = r_dmem_be;
    w_addr_lo_nxt       = r_addr_lo;
    w_funct3_nxt        = r_funct3;
    w_rd_nxt            = r_rd;
    w_wr_en_nxt         = r_wr_en;
    w_is_load_nxt       = r_is_load;
    w_wb_valid_nxt      = 1'b0;
    w_wb_wr_data_en_nxt = r_wb_wr_data_en;
    w_wb_rd_nxt         = r_wb_rd;
    w_wb_data_nxt       = r_wb_data;
    w_wb_misalign_nxt   = r_wb_misalign;
    w_wb_bus_err_nxt    = r_wb_bus_err;
    w_enter_req         = 1'b0;

    case (r_state)
      IDLE: begin
        if (ex_valid) begin
          if (!w_is_mem || w_misalign) begin
            // Completes immediately; a misaligned access never reaches memory
            w_wb_valid_nxt      = 1'b1;
            w_wb_data_nxt       = ex_alu_out;
            w_wb_rd_nxt         = ex_rd;
            w_wb_wr_data_en_nxt = ex_wr_data_en & ~w_is_mem;
            w_wb_misalign_nxt   = w_is_mem;
            w_wb_bus_err_nxt    = 1'b0;
          end else begin
            w_state_nxt      = REQ;
            w_enter_req      = 1'b1;
            w_dmem_we_nxt    = ex_store_en;
            w_dmem_addr_nxt  = {ex_alu_out[XLEN-1:2], 2'b00};
            w_dmem_wdata_nxt = lane_wdata(ex_funct3, ex_store_data);
            w_dmem_be_nxt    = lane_be(ex_funct3, ex_alu_out[1:0]);
            w_addr_lo_nxt    = ex_alu_out[1:0];
            w_funct3_nxt     = ex_funct3;
            w_rd_nxt         = ex_rd;
            w_wr_en_nxt      = ex_wr_data_en;
            w_is_load_nxt    = ex_load_en;
          end
        end
      end
      REQ: begin
        if (dmem_ack) begin
          w_state_nxt         = IDLE;
          w_wb_valid_nxt      = 1'b1;
          w_wb_rd_nxt         = r_rd;
          w_wb_wr_data_en_nxt = r_is_load & r_wr_en;
          w_wb_data_nxt       = r_is_load ? w_load_data
                                          : {r_dmem_addr[XLEN-1:2], r_addr_lo};
          w_wb_misalign_nxt   = 1'b0;
          w_wb_bus_err_nxt    = 1'b0;
        end else if (w_timeout) begin
          w_state_nxt         = IDLE;
          w_wb_valid_nxt      = 1'b1;
          w_wb_rd_nxt         = r_rd;
          w_wb_wr_data_en_nxt = 1'b0;
          w_wb_data_nxt       = '0;
          w_wb_misalign_nxt   = 1'b0;
          w_wb_bus_err_nxt    = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge risc_clk) begin
    if (!risc_rst_n) begin
      r_state         <= IDLE;
      r_dmem_we       <= 1'b0;
      r_dmem_addr     <= '0;
      r_dmem_wdata    <= '0;
      r_dmem_be       <= 4'h0;
      r_addr_lo       <= 2'b00;
      r_funct3        <= 3'b000;
      r_rd            <= 5'd0;
      r_wr_en         <= 1'b0;
      r_is_load       <= 1'b0;
      r_wb_valid      <= 1'b0;
      r_wb_wr_data_en <= 1'b0;
      r_wb_rd         <= 5'd0;
      r_wb_data       <= '0;
      r_wb_misalign   <= 1'b0;
      r_wb_bus_err    <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_dmem_we       <= w_dmem_we_nxt;
      r_dmem_addr     <= w_dmem_addr_nxt;
      r_dmem_wdata    <= w_dmem_wdata_nxt;
      r_dmem_be       <= w_dmem_be_nxt;
      r_addr_lo       <= w_addr_lo_nxt;
      r_funct3        <= w_funct3_nxt;
      r_rd            <= w_rd_nxt;
      r_wr_en         <= w_wr_en_nxt;
      r_is_load       <= w_is_load_nxt;
      r_wb_valid      <= w_wb_valid_nxt;
      r_wb_wr_data_en <= w_wb_wr_data_en_nxt;
      r_wb_rd         <= w_wb_rd_nxt;
      r_wb_data       <= w_wb_data_nxt;
      r_wb_misalign   <= w_wb_misalign_nxt;
      r_wb_bus_err    <= w_wb_bus_err_nxt;
    end
  end

  // Request and stall are decodes of the registered state
  assign mem_stall     = (r_state == REQ);
  assign dmem_req      = (r_state == REQ);
  assign dmem_we       = r_dmem_we;
  assign dmem_addr     = r_dmem_addr;
  assign dmem_wdata    = r_dmem_wdata;
  assign dmem_be       = r_dmem_be;
  assign wb_valid      = r_wb_valid;
  assign wb_wr_data_en = r_wb_wr_data_en;
  assign wb_rd         = r_wb_rd;
  assign wb_data       = r_wb_data;
  assign wb_misalign   = r_wb_misalign;
  assign wb_bus_err    = r_wb_bus_err;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage of the zilla_32 RISC-V pipeline, between the execute stage and the write-back stage. Passes ALU results through to write-back and executes loads and stores against the data memory over a req/ack handshake. Handles byte/halfword lane steering, load sign/zero extension, misalignment detection and pipeline stall. All outputs to write-back are registered, forming the MEM/WB boundary.

## Interface
Parameters:
- `XLEN`, 32: datapath width; only 32 is supported.
- `ACK_TIMEOUT`, 64: cycles to wait for `dmem_ack` before declaring a bus error (only with `MEM_ACK_TIMEOUT_EN`).

Ports (one clock `risc_clk`; reset `risc_rst_n` is synchronous, active-low):
- `risc_clk`  in  1  clock
- `risc_rst_n`  in  1  synchronous active-low reset
- `ex_valid`  in  1  execute stage presents an instruction
- `ex_alu_out`  in  32  ALU result; this is the address for loads and stores
- `ex_store_data`  in  32  rs2 value for stores
- `ex_rd`  in  5  destination register
- `ex_funct3`  in  3  access size/sign
- `ex_load_en` / `ex_store_en`  in  1 each  memory op type; mutually exclusive
- `ex_wr_data_en`  in  1  instruction writes the GPR
- `mem_stall`  out  1  upstream must hold `ex_*` stable
- `dmem_req`, `dmem_we`  out  1 each  request, write strobe
- `dmem_addr`  out  32  word address; [1:0]=0
- `dmem_wdata`  out  32  lane-steered store data
- `dmem_be`  out  4  byte enables
- `dmem_ack`  in  1  request completes this cycle
- `dmem_rdata`  in  32  read data, valid with ack
- `wb_valid`, `wb_wr_data_en`  out  1 each  to write-back
- `wb_rd`  out  5  to write-back
- `wb_data`  out  32  result/load data
- `wb_misalign`, `wb_bus_err`  out  1 each  exception flags, qualified by `wb_valid`

## Operation
- Accept = `ex_valid & ~mem_stall` at a rising edge.
- FSM states IDLE and REQ. `mem_stall` = (state==REQ).
- Non-memory op accepted: stay in IDLE. `wb_data`=`ex_alu_out`; `wb_rd`, `wb_wr_data_en` forwarded.
- Misaligned access:
  - Condition: halfword (funct3[1:0]=01) with addr[0]=1, or word (10) with addr[1:0]≠0.
  - No dmem request; `wb_misalign`=1, `wb_wr_data_en`=0, `wb_data`=address.
- Aligned load/store accepted: capture address, funct3, rd, data; go to REQ.
  - In REQ: `dmem_req`=1 and address, data, `we`, `be` are held constant until `dmem_ack`.
  - On ack: go to IDLE.
- Store lanes:
  - SB: `be` = 1<<addr[1:0], byte replicated ×4.
  - SH: `be` = 0011 or 1100, half replicated ×2.
  - SW: `be` = 1111.
  - Stores set `wb_wr_data_en`=0.
- Load extract: select byte/half by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through. Funct3 011/110/111 on a memory op is treated as LW.
- Reset: `wb_valid`, `wb_wr_data_en`, `wb_misalign`, `wb_bus_err`, `dmem_req`, `dmem_we`, `mem_stall` = 0. `wb_data`, `wb_rd`, `dmem_addr`, `dmem_wdata`, `dmem_be` = 0. State = IDLE.
- Reset asserted while in REQ: `dmem_req` drops at the next edge; the outstanding access is abandoned. The memory side must tolerate a dropped request.

## Timing
- Non-memory/misaligned op accepted at edge T: `wb_valid`=1 for exactly the cycle after T.
- Memory op accepted at edge T:
  - `dmem_req` and `mem_stall` are high from T+1.
  - Ack sampled at edge A (the earliest possible A is the end of cycle T+1): `wb_valid`=1 and `wb_data` = extracted rdata in the cycle after A. `dmem_req` and `mem_stall` are low from that same cycle.
- Single-cycle memory gives a load-to-WB latency of 2 cycles and one bubble per memory op.
- `wb_valid` is low in every cycle with no completion; `wb_*` payload is don't-care there but holds its last value.
- `dmem_ack` outside REQ is ignored.

## Configuration
- `MEM_ACK_TIMEOUT_EN` defined:
  - A counter clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches `ACK_TIMEOUT` with no ack, the FSM returns to IDLE and completes with `wb_bus_err`=1, `wb_wr_data_en`=0, `wb_data`=0.
  - Ack in the same cycle as expiry wins and completes normally.
- Undefined: no counter; REQ waits for ack indefinitely and `wb_bus_err` is tied 0.

## Structure
- Package `riscv_mem_pkg`: funct3 constants (LB..LHU, SB..SW) and `mem_state_t` enum {IDLE, REQ}.
- One sub-module `load_align`: combinational rdata + addr[1:0] + funct3 → 32-bit extended load value.

## Test plan
- ADD result 0x0000_1234, rd=5 → `wb_valid` next cycle, `wb_data`=0x1234, `wb_rd`=5, no `dmem_req`.
- LB at 0x103, rdata 0x80AA_BBCC, ack after 3 REQ cycles → `mem_stall` high 3 cycles; then `wb_data`=0xFFFF_FF80.
- LHU at 0x102, rdata 0x8001_0000 → `wb_data`=0x0000_8001; SH at 0x102 with data 0x1234 → `be`=1100, `wdata`=0x1234_1234.
- LW at 0x101 → no request; `wb_misalign`=1, `wb_wr_data_en`=0, `wb_valid` next cycle.
- Reset during REQ → `dmem_req` 0 at next edge; all outputs at reset values; next op proceeds normally.
- `MEM_ACK_TIMEOUT_EN`, `ACK_TIMEOUT`=4, no ack → `wb_bus_err`=1 after 4 REQ cycles; with ack in the 4th cycle → normal completion.
